zbuf_frame_controller: RTL and testbench

Sequences the frame and depth buffer ports driven by the fragment shader. After reset, or on a clear request, it sweeps every pixel address and writes the background colour and the far depth value. While the sweep runs it holds the rasterizer off. Outside the sweep it forwards shader write traffic to the memory ports, so it sits between the fragment shader outputs and the frame-buffer/Z-buffer BRAM write ports.

---
 rtl/zbuf_frame_controller_pkg.sv | 18 +
 rtl/zbuf_frame_controller_if.sv | 36 +++
 rtl/zbuf_frame_controller_clear_addr_gen.sv | 36 +++
 rtl/zbuf_frame_controller.sv | 117 +++++++++++
 tb/tb_zbuf_frame_controller.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/zbuf_frame_controller_pkg.sv
// Shared rendering definitions for the frame/depth buffer controller.
//   - address, pixel and depth widths
//   - controller state encoding
//   - default background colour and far depth
package render_pkg;
  localparam int FB_ADDR_W = 17;
  localparam int PIXEL_W   = 12;
  localparam int Z_W       = 8;

  localparam logic [PIXEL_W-1:0] DEF_CLEAR_COLOR = 12'h000;
  localparam logic [Z_W-1:0]     DEF_CLEAR_Z     = 8'hFF;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_t;
endpackage

// File: rtl/zbuf_frame_controller_if.sv
// Write bus between the fragment shader, the controller and the buffer BRAMs.
//   i_sh_*  : shader frame-buffer / Z-buffer write requests (into controller)
//   o_fb_*  : frame-buffer write port (out of controller)
//   o_zb_*  : Z-buffer write port (out of controller)
// master = shader/memory side, slave = controller.
interface zbuf_frame_controller_if;
  import render_pkg::*;

  logic                 i_sh_fb_we;
  logic [FB_ADDR_W-1:0] i_sh_fb_addr;
  logic [PIXEL_W-1:0]   i_sh_fb_pixel;
  logic                 i_sh_zb_we;
  logic [FB_ADDR_W-1:0] i_sh_zb_addr;
  logic [Z_W-1:0]       i_sh_zb_val;

  logic                 o_fb_we;
  logic [FB_ADDR_W-1:0] o_fb_addr;
  logic [PIXEL_W-1:0]   o_fb_pixel;
  logic                 o_zb_we;
  logic [FB_ADDR_W-1:0] o_zb_addr;
  logic [Z_W-1:0]       o_zb_val;

  modport master (
    output i_sh_fb_we, i_sh_fb_addr, i_sh_fb_pixel,
    output i_sh_zb_we, i_sh_zb_addr, i_sh_zb_val,
    input  o_fb_we, o_fb_addr, o_fb_pixel,
    input  o_zb_we, o_zb_addr, o_zb_val
  );

  modport slave (
    input  i_sh_fb_we, i_sh_fb_addr, i_sh_fb_pixel,
    input  i_sh_zb_we, i_sh_zb_addr, i_sh_zb_val,
    output o_fb_we, o_fb_addr, o_fb_pixel,
    output o_zb_we, o_zb_addr, o_zb_val
  );
endinterface

// File: rtl/zbuf_frame_controller_clear_addr_gen.sv
// Sweep address counter for the buffer clear.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_start        : restart the sweep at address 0
//   i_en           : advance one address (a clear write is issued this cycle)
//   o_cnt          : current sweep address
//   o_last         : o_cnt is the final address (NUM_PIXELS-1)
module clear_addr_gen
  import render_pkg::*;
#(
  parameter int NUM_PIXELS = 76800
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_en,
  output logic [FB_ADDR_W-1:0] o_cnt,
  output logic                 o_last
);
  logic [FB_ADDR_W-1:0] cnt_q, cnt_d;

  assign o_last = (cnt_q == FB_ADDR_W'(NUM_PIXELS - 1));
  assign o_cnt  = cnt_q;

  // Returning to 0 after the last address leaves the counter ready for the
  // next sweep, so it never runs past NUM_PIXELS-1.
  always_comb begin
    cnt_d = cnt_q;
    if (i_start)     cnt_d = '0;
    else if (i_en)   cnt_d = o_last ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/zbuf_frame_controller.sv
// Frame/Z-buffer write sequencer between the fragment shader and the BRAMs.
// Clears both buffers after reset or on request, holding the rasterizer off,
// and otherwise forwards shader writes with one register stage.
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_clear_req      : one-cycle clear request (honoured only in RUN)
//   o_raster_ready   : rasterizer may issue pixels (RUN)
//   o_busy           : drain or clear in progress
//   o_clear_done     : one-cycle pulse on the first RUN cycle after a clear
//   o_drop_err       : sticky, a shader write arrived during a clear
//   bus              : shader request inputs and BRAM write ports
module zbuf_frame_controller
  import render_pkg::*;
#(
  parameter int                 NUM_PIXELS  = 76800,
  parameter int                 PIPE_DEPTH  = 3,
  parameter logic [PIXEL_W-1:0] CLEAR_COLOR = DEF_CLEAR_COLOR,
  parameter logic [Z_W-1:0]     CLEAR_Z     = DEF_CLEAR_Z
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear_req,
  output logic                    o_raster_ready,
  output logic                    o_busy,
  output logic                    o_clear_done,
  output logic                    o_drop_err,
  zbuf_frame_controller_if.slave  bus
);
  localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  ctrl_state_t          state_q;
  logic [DW-1:0]        drain_q;
  logic                 done_q, drop_q;
  logic                 fb_we_q, zb_we_q;
  logic [FB_ADDR_W-1:0] fb_addr_q, zb_addr_q;
  logic [PIXEL_W-1:0]   fb_pix_q;
  logic [Z_W-1:0]       zb_val_q;

  logic [FB_ADDR_W-1:0] cnt;
  logic                 cnt_last;
  logic                 drain_end;

  assign drain_end = (state_q == DRAIN) && (drain_q == DW'(PIPE_DEPTH - 1));

  clear_addr_gen #(.NUM_PIXELS(NUM_PIXELS)) u_addr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (drain_end),
    .i_en    (state_q == CLEAR),
    .o_cnt   (cnt),
    .o_last  (cnt_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= CLEAR;
      drain_q   <= '0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_pix_q  <= '0;
      zb_we_q   <= 1'b0;
      zb_addr_q <= '0;
      zb_val_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        CLEAR: begin
          fb_we_q   <= 1'b1;
          fb_addr_q <= cnt;
          fb_pix_q  <= CLEAR_COLOR;
          zb_we_q   <= 1'b1;
          zb_addr_q <= cnt;
          zb_val_q  <= CLEAR_Z;
          if (bus.i_sh_fb_we || bus.i_sh_zb_we) drop_q <= 1'b1;
          // done lands together with the first RUN cycle
          if (cnt_last) begin
            state_q <= RUN;
            done_q  <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          // shader traffic keeps flowing while the pipeline drains
          fb_we_q   <= bus.i_sh_fb_we;
          fb_addr_q <= bus.i_sh_fb_addr;
          fb_pix_q  <= bus.i_sh_fb_pixel;
          zb_we_q   <= bus.i_sh_zb_we;
          zb_addr_q <= bus.i_sh_zb_addr;
          zb_val_q  <= bus.i_sh_zb_val;
          if (state_q == RUN) begin
            if (i_clear_req) begin
              state_q <= DRAIN;
              drain_q <= '0;
            end
          end else if (drain_end) begin
            state_q <= CLEAR;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign o_raster_ready = (state_q == RUN);
  assign o_busy         = !o_raster_ready;
  assign o_clear_done   = done_q;
  assign o_drop_err     = drop_q;

  assign bus.o_fb_we    = fb_we_q;
  assign bus.o_fb_addr  = fb_addr_q;
  assign bus.o_fb_pixel = fb_pix_q;
  assign bus.o_zb_we    = zb_we_q;
  assign bus.o_zb_addr  = zb_addr_q;
  assign bus.o_zb_val   = zb_val_q;
endmodule

// File: tb/tb_zbuf_frame_controller.sv
// Randomized self-checking bench for zbuf_frame_controller (16-pixel buffer).
module tb_zbuf_frame_controller;
  import render_pkg::*;

  localparam int          N    = 16;
  localparam int          PD   = 3;
  localparam logic [11:0] CCOL = 12'h000;
  localparam logic [7:0]  CZ   = 8'hFF;

  logic gclk = 1'b0;
  logic grst_n;
  logic clear_req;
  logic raster_ready, busy, clear_done, drop_err;

  zbuf_frame_controller_if bus();

  zbuf_frame_controller #(
    .NUM_PIXELS(N), .PIPE_DEPTH(PD), .CLEAR_COLOR(CCOL), .CLEAR_Z(CZ)
  ) dut (
    .i_clk          (gclk),
    .i_rst_n        (grst_n),
    .i_clear_req    (clear_req),
    .o_raster_ready (raster_ready),
    .o_busy         (busy),
    .o_clear_done   (clear_done),
    .o_drop_err     (drop_err),
    .bus            (bus)
  );

  always #5 gclk = ~gclk;

  int n_chk = 0;
  int n_err = 0;
  bit exp_drop = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic sh_idle();
    bus.i_sh_fb_we = 0; bus.i_sh_fb_addr = '0; bus.i_sh_fb_pixel = '0;
    bus.i_sh_zb_we = 0; bus.i_sh_zb_addr = '0; bus.i_sh_zb_val = '0;
  endtask

  task automatic sh_rand();
    bus.i_sh_fb_we    = 1'($urandom);
    bus.i_sh_fb_addr  = 17'($urandom_range(0, N - 1));
    bus.i_sh_fb_pixel = 12'($urandom);
    bus.i_sh_zb_we    = 1'($urandom);
    bus.i_sh_zb_addr  = 17'($urandom_range(0, N - 1));
    bus.i_sh_zb_val   = 8'($urandom);
  endtask

  // One forwarding cycle: whatever the shader presents shows up on the ports
  // one edge later, unchanged.
  task automatic fwd_cycle(input bit clr, input bit exp_ready, input bit directed);
    logic fwe, zwe;
    logic [16:0] fa, za;
    logic [11:0] fp;
    logic [7:0] zv;
    if (!directed) sh_rand();
    clear_req = clr;
    fwe = bus.i_sh_fb_we; fa = bus.i_sh_fb_addr; fp = bus.i_sh_fb_pixel;
    zwe = bus.i_sh_zb_we; za = bus.i_sh_zb_addr; zv = bus.i_sh_zb_val;
    tick();
    clear_req = 1'b0;
    chk("fwd_fb_we", bus.o_fb_we, fwe);
    chk("fwd_zb_we", bus.o_zb_we, zwe);
    if (fwe) begin
      chk("fwd_fb_addr", bus.o_fb_addr, fa);
      chk("fwd_fb_pixel", bus.o_fb_pixel, fp);
    end
    if (zwe) begin
      chk("fwd_zb_addr", bus.o_zb_addr, za);
      chk("fwd_zb_val", bus.o_zb_val, zv);
    end
    chk("fwd_ready", raster_ready, exp_ready);
    chk("fwd_busy", busy, !exp_ready);
    chk("fwd_done", clear_done, 1'b0);
    chk("fwd_drop", drop_err, exp_drop);
  endtask

  // Observe n sweep writes starting at address 0. A shader write is injected
  // at index drop_at and a clear request at index clr_at (-1 = none).
  task automatic sweep(input int n, input int drop_at, input int clr_at, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      sh_idle();
      if (i == drop_at) begin
        sh_rand();
        if (!bus.i_sh_fb_we && !bus.i_sh_zb_we) bus.i_sh_zb_we = 1'b1;
        exp_drop = 1'b1;
      end
      clear_req = (i == clr_at);
      tick();
      clear_req = 1'b0;
      chk("clr_fb_we", bus.o_fb_we, 1'b1);
      chk("clr_zb_we", bus.o_zb_we, 1'b1);
      chk("clr_fb_addr", bus.o_fb_addr, 32'(i));
      chk("clr_zb_addr", bus.o_zb_addr, 32'(i));
      chk("clr_fb_pixel", bus.o_fb_pixel, CCOL);
      chk("clr_zb_val", bus.o_zb_val, CZ);
      chk("clr_done", clear_done, (i == N - 1));
      chk("clr_ready", raster_ready, (i == N - 1));
      chk("clr_busy", busy, (i != N - 1));
      chk("clr_drop", drop_err, exp_drop);
      if (clear_done) dones++;
    end
    sh_idle();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_fb_we"}, bus.o_fb_we, 1'b0);
    chk({tag, "_zb_we"}, bus.o_zb_we, 1'b0);
    chk({tag, "_fb_addr"}, bus.o_fb_addr, '0);
    chk({tag, "_zb_addr"}, bus.o_zb_addr, '0);
    chk({tag, "_fb_pixel"}, bus.o_fb_pixel, '0);
    chk({tag, "_zb_val"}, bus.o_zb_val, '0);
    chk({tag, "_done"}, clear_done, 1'b0);
    chk({tag, "_drop"}, drop_err, 1'b0);
    chk({tag, "_ready"}, raster_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b1);
  endtask

  task automatic request_clear();
    fwd_cycle(1'b1, 1'b0, 1'b0);            // request edge: forwarded, ready drops
    for (int d = 0; d < PD; d++) fwd_cycle(1'b0, 1'b0, 1'b0);  // drain
  endtask

  initial begin
    int dones;
    grst_n = 1'b0;
    clear_req = 1'b0;
    sh_idle();
    tick(); tick();
    chk_reset_vals("rst");

    // Power-up sweep
    grst_n = 1'b1;
    sweep(N, -1, -1, dones);
    chk("pwrup_dones", dones, 1);

    // Directed forward of fb/zb to address 5
    bus.i_sh_fb_we = 1; bus.i_sh_fb_addr = 17'd5; bus.i_sh_fb_pixel = 12'hF0A;
    bus.i_sh_zb_we = 1; bus.i_sh_zb_addr = 17'd5; bus.i_sh_zb_val = 8'h20;
    fwd_cycle(1'b0, 1'b1, 1'b1);
    sh_idle();

    // Random RUN traffic, then a clear with a dropped write and an ignored
    // second request inside the sweep.
    for (int r = 0; r < 30; r++) fwd_cycle(1'b0, 1'b1, 1'b0);
    request_clear();
    sweep(N, $urandom_range(0, N - 1), $urandom_range(0, N - 1), dones);
    chk("sweep2_dones", dones, 1);
    chk("drop_set", drop_err, 1'b1);
    for (int r = 0; r < 20; r++) fwd_cycle(1'b0, 1'b1, 1'b0);

    // Clear without any dropped writes: drop flag must remain sticky.
    request_clear();
    sweep(N, -1, -1, dones);
    chk("sweep3_dones", dones, 1);
    for (int r = 0; r < 10; r++) fwd_cycle(1'b0, 1'b1, 1'b0);

    // Reset while the sweep shows address 7.
    request_clear();
    sweep(8, -1, -1, dones);
    grst_n = 1'b0;
    #1;
    exp_drop = 1'b0;
    chk_reset_vals("midrst");
    tick(); tick();
    grst_n = 1'b1;
    sweep(N, -1, -1, dones);
    chk("restart_dones", dones, 1);
    for (int r = 0; r < 10; r++) fwd_cycle(1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
